// File: rtl/inv_video_scan_if.sv
// Scan-stage bus: VRAM fetch port, video timing/pixel outputs and the CPU interrupt handshake.
interface inv_video_scan_if;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic        pix;
  logic        blank;
  logic        hsync_n;
  logic        vsync_n;
  logic [8:0]  hcnt;
  logic [8:0]  vcnt;
  logic        int_req;
  logic [7:0]  int_vec;
  logic        int_ack;

  modport master (
    output vram_addr, vram_rd, pix, blank, hsync_n, vsync_n, hcnt, vcnt, int_req, int_vec,
    input  vram_data, int_ack
  );
  modport slave (
    input  vram_addr, vram_rd, pix, blank, hsync_n, vsync_n, hcnt, vcnt, int_req, int_vec,
    output vram_data, int_ack
  );
endinterface

// File: rtl/inv_video_scan.sv
// Invaders raster scan: h/v timing, 1bpp VRAM fetch, LSB-first pixel serializer, RST 1/RST 2 requests.
module inv_video_scan #(
  parameter logic [8:0]  H_TOTAL   = 9'd320,
  parameter logic [8:0]  H_ACTIVE  = 9'd256,
  parameter logic [8:0]  HS_START  = 9'd272,
  parameter logic [8:0]  HS_END    = 9'd304,
  parameter logic [8:0]  V_TOTAL   = 9'd262,
  parameter logic [8:0]  V_ACTIVE  = 9'd224,
  parameter logic [8:0]  VS_START  = 9'd236,
  parameter logic [8:0]  VS_END    = 9'd240,
  parameter logic [8:0]  MID_LINE  = 9'd96,
  parameter logic [15:0] VRAM_BASE = 16'h2400
) (
  input  logic            c,
  input  logic            r,
  input  logic            ce,
  inv_video_scan_if.master bus
);
  localparam logic [7:0] RST1 = 8'hCF;
  localparam logic [7:0] RST2 = 8'hD7;

  logic [8:0]  hcnt, vcnt, hn, vn, fline;
  logic [4:0]  fgrp;
  logic        fire, evt_mid, evt_vbl, blank_w;
  logic [7:0]  shifter, data_q;
  logic [1:0]  vld_pipe;
  logic [15:0] addr_q;
  logic        rd_q, req_q;
  logic [7:0]  vec_q;

  always_comb begin
    hn = hcnt + 9'd1;
    vn = vcnt;
    if (hcnt == H_TOTAL - 9'd1) begin
      hn = '0;
      vn = (vcnt == V_TOTAL - 9'd1) ? '0 : vcnt + 9'd1;
    end
  end

  // Strobes are decoded from the next counter value so vram_rd is high while hcnt sits on the fetch point.
  always_comb begin
    fline = vn;
    fgrp  = '0;
    fire  = 1'b0;
    if (hn == H_TOTAL - 9'd4) begin
      fline = (vn == V_TOTAL - 9'd1) ? '0 : vn + 9'd1;
      fire  = 1'b1;
    end else if (hn[2:0] == 3'd4 && hn < H_ACTIVE - 9'd4) begin
      fgrp = hn[7:3] + 5'd1;
      fire = 1'b1;
    end
    fire = fire && (fline < V_ACTIVE);
  end

  assign evt_mid = ce && (hn == 9'd0) && (vn == MID_LINE);
  assign evt_vbl = ce && (hn == 9'd0) && (vn == V_ACTIVE);

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      hcnt     <= '0;
      vcnt     <= '0;
      rd_q     <= 1'b0;
      addr_q   <= VRAM_BASE;
      vld_pipe <= '0;
      data_q   <= '0;
      shifter  <= '0;
    end else if (ce) begin
      hcnt     <= hn;
      vcnt     <= vn;
      rd_q     <= fire;
      if (fire) addr_q <= VRAM_BASE + {2'b00, fline, 5'b00000} + {11'd0, fgrp};
      vld_pipe <= {vld_pipe[0], rd_q};
      // Capture point: a group with no fetch behind it feeds zeros to the shifter.
      if (hcnt[2:0] == 3'd6) data_q <= vld_pipe[1] ? bus.vram_data : 8'h00;
      if (hcnt[2:0] == 3'd7) shifter <= data_q;
      else                   shifter <= shifter >> 1;
    end
  end

  // Ack is honoured every clock; a coincident frame event takes priority over it.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      req_q <= 1'b0;
      vec_q <= 8'h00;
    end else if (evt_mid || evt_vbl) begin
      req_q <= 1'b1;
      vec_q <= evt_mid ? RST1 : RST2;
    end else if (bus.int_ack) begin
      req_q <= 1'b0;
    end
  end

  assign blank_w       = (hcnt >= H_ACTIVE) || (vcnt >= V_ACTIVE);
  assign bus.blank     = blank_w;
  assign bus.hsync_n   = !((hcnt >= HS_START) && (hcnt < HS_END));
  assign bus.vsync_n   = !((vcnt >= VS_START) && (vcnt < VS_END));
  assign bus.pix       = shifter[0] & ~blank_w;
  assign bus.hcnt      = hcnt;
  assign bus.vcnt      = vcnt;
  assign bus.vram_rd   = rd_q;
  assign bus.vram_addr = addr_q;
  assign bus.int_req   = req_q;
  assign bus.int_vec   = vec_q;
endmodule

// File: tb/tb_inv_video_scan.sv
// Bench for inv_video_scan: position-based reference model, table of timing/fetch points, interrupt and reset sequences.
module tb_inv_video_scan;
  localparam int HT = 320, HA = 256, HSS = 272, HSE = 304;
  localparam int VT = 30, VA = 20, VSS = 24, VSE = 26, MID = 8;
  localparam logic [15:0] BASE = 16'h2400;

  logic c = 1'b0, r = 1'b0, ce = 1'b0, ack = 1'b0, force_ff = 1'b0;
  logic [7:0] mem [0:1023];

  inv_video_scan_if bus();

  inv_video_scan #(
    .V_TOTAL(9'(VT)), .V_ACTIVE(9'(VA)), .VS_START(9'(VSS)), .VS_END(9'(VSE)), .MID_LINE(9'(MID))
  ) dut (.c(c), .r(r), .ce(ce), .bus(bus));

  always #5 c = ~c;

  assign bus.vram_data = force_ff ? 8'hFF : mem[10'(bus.vram_addr - BASE)];
  assign bus.int_ack   = ack;

  int checks = 0, errors = 0;
  int mh = 0, mv = 0, mframe = 0;
  logic        m_req  = 1'b0;
  logic [7:0]  m_vec  = 8'h00;
  logic [15:0] m_addr = BASE;

  typedef struct {
    int h; int v;
    logic blank; logic hs; logic vs; logic rd;
    logic [15:0] addr;
    logic cp; logic pix;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (pos h=%0d v=%0d frame=%0d)", nm, act, exp, mh, mv, mframe);
    end
  endtask

  // A byte fetch belongs to group g of line v at pixel 8g-4 (g=0 lands at the end of the previous line).
  function automatic bit fetch_at(input int h, input int v, output logic [15:0] a);
    int line, g;
    a = 16'h0;
    if (h == HT - 4) begin
      line = (v + 1) % VT; g = 0;
    end else if (h % 8 == 4 && h < HA - 4) begin
      line = v; g = (h + 4) / 8;
    end else return 1'b0;
    if (line >= VA) return 1'b0;
    a = 16'(BASE + line * 32 + g);
    return 1'b1;
  endfunction

  function automatic logic exp_pix();
    int g;
    logic [7:0] byt;
    if (mh >= HA || mv >= VA) return 1'b0;
    g = mh / 8;
    // The first group of line 0 is never fetched in the frame right after reset.
    byt = (mframe == 0 && mv == 0 && g == 0) ? 8'h00 : mem[10'(mv * 32 + g)];
    return byt[3'(mh % 8)];
  endfunction

  task automatic model_check();
    logic [15:0] a;
    logic rd;
    rd = fetch_at(mh, mv, a);
    chk("hcnt",      32'(bus.hcnt), 32'(mh));
    chk("vcnt",      32'(bus.vcnt), 32'(mv));
    chk("blank",     32'(bus.blank), 32'((mh >= HA) || (mv >= VA)));
    chk("hsync_n",   32'(bus.hsync_n), 32'(!(mh >= HSS && mh < HSE)));
    chk("vsync_n",   32'(bus.vsync_n), 32'(!(mv >= VSS && mv < VSE)));
    chk("vram_rd",   32'(bus.vram_rd), 32'(rd));
    chk("vram_addr", 32'(bus.vram_addr), 32'(m_addr));
    chk("pix",       32'(bus.pix), 32'(exp_pix()));
    chk("int_req",   32'(bus.int_req), 32'(m_req));
    chk("int_vec",   32'(bus.int_vec), 32'(m_vec));
  endtask

  task automatic step(input logic ce_v, input logic ack_v);
    logic [15:0] a;
    ce  = ce_v;
    ack = ack_v;
    force_ff = (mv >= VA && mv < VT - 1) || (mh >= 248 && mh <= 314);
    @(posedge c);
    if (ce_v) begin
      mh++;
      if (mh == HT) begin
        mh = 0; mv++;
        if (mv == VT) begin mv = 0; mframe++; end
      end
      if (fetch_at(mh, mv, a)) m_addr = a;
    end
    if (ce_v && mh == 0 && mv == MID)     begin m_req = 1'b1; m_vec = 8'hCF; end
    else if (ce_v && mh == 0 && mv == VA) begin m_req = 1'b1; m_vec = 8'hD7; end
    else if (ack_v) m_req = 1'b0;
    @(negedge c);
    model_check();
  endtask

  task automatic goto_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < 2 * HT * VT) begin step(1'b1, 1'b0); n++; end
    if (!(mh == h && mv == v)) begin
      checks++; errors++;
      $display("FAIL goto_pos: timed out at h=%0d v=%0d want h=%0d v=%0d", mh, mv, h, v);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[160] = 8'b0000_0101;

    //          h    v   blk hs vs rd  addr      cp pix
    tbl.push_back('{  0,  0, 0, 1, 1, 0, 16'h2400, 1, 0});
    tbl.push_back('{  4,  0, 0, 1, 1, 1, 16'h2401, 0, 0});
    tbl.push_back('{  5,  0, 0, 1, 1, 0, 16'h2401, 0, 0});
    tbl.push_back('{255,  0, 0, 1, 1, 0, 16'h241F, 0, 0});
    tbl.push_back('{256,  0, 1, 1, 1, 0, 16'h241F, 1, 0});
    tbl.push_back('{271,  0, 1, 1, 1, 0, 16'h241F, 0, 0});
    tbl.push_back('{272,  0, 1, 0, 1, 0, 16'h241F, 0, 0});
    tbl.push_back('{303,  0, 1, 0, 1, 0, 16'h241F, 0, 0});
    tbl.push_back('{304,  0, 1, 1, 1, 0, 16'h241F, 0, 0});
    tbl.push_back('{316,  0, 1, 1, 1, 1, 16'h2420, 0, 0});
    tbl.push_back('{316,  4, 1, 1, 1, 1, 16'h24A0, 0, 0});
    tbl.push_back('{317,  4, 1, 1, 1, 0, 16'h24A0, 0, 0});
    tbl.push_back('{  0,  5, 0, 1, 1, 0, 16'h24A0, 1, 1});
    tbl.push_back('{  1,  5, 0, 1, 1, 0, 16'h24A0, 1, 0});
    tbl.push_back('{  2,  5, 0, 1, 1, 0, 16'h24A0, 1, 1});
    tbl.push_back('{  3,  5, 0, 1, 1, 0, 16'h24A0, 1, 0});
    tbl.push_back('{  4,  5, 0, 1, 1, 1, 16'h24A1, 1, 0});
    tbl.push_back('{  7,  5, 0, 1, 1, 0, 16'h24A1, 1, 0});
    tbl.push_back('{316, 19, 1, 1, 1, 0, 16'h267F, 0, 0});
    tbl.push_back('{  0, 20, 1, 1, 1, 0, 16'h267F, 1, 0});
    tbl.push_back('{  0, 23, 1, 1, 1, 0, 16'h267F, 0, 0});
    tbl.push_back('{  0, 24, 1, 1, 0, 0, 16'h267F, 0, 0});
    tbl.push_back('{319, 25, 1, 1, 0, 0, 16'h267F, 0, 0});
    tbl.push_back('{  0, 26, 1, 1, 1, 0, 16'h267F, 0, 0});
    tbl.push_back('{316, 29, 1, 1, 1, 1, 16'h2400, 0, 0});
    tbl.push_back('{319, 29, 1, 1, 1, 0, 16'h2400, 0, 0});

    repeat (3) @(negedge c);
    model_check();
    r = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      goto_pos(tbl[i].h, tbl[i].v);
      chk("tbl_blank",   32'(bus.blank),     32'(tbl[i].blank));
      chk("tbl_hsync_n", 32'(bus.hsync_n),   32'(tbl[i].hs));
      chk("tbl_vsync_n", 32'(bus.vsync_n),   32'(tbl[i].vs));
      chk("tbl_vram_rd", 32'(bus.vram_rd),   32'(tbl[i].rd));
      chk("tbl_addr",    32'(bus.vram_addr), 32'(tbl[i].addr));
      if (tbl[i].cp) chk("tbl_pix", 32'(bus.pix), 32'(tbl[i].pix));
    end

    // Interrupt handshake across frames 1 and 2.
    goto_pos(0, 0);
    step(1'b1, 1'b1);
    chk("ack_clear_vbl", 32'(bus.int_req), 32'd0);
    goto_pos(0, MID);
    chk("mid_req", 32'(bus.int_req), 32'd1);
    chk("mid_vec", 32'(bus.int_vec), 32'hCF);
    repeat (9) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("ack_drop_req", 32'(bus.int_req), 32'd0);
    chk("ack_vec_hold", 32'(bus.int_vec), 32'hCF);
    goto_pos(0, VA);
    chk("vbl_req", 32'(bus.int_req), 32'd1);
    chk("vbl_vec", 32'(bus.int_vec), 32'hD7);
    goto_pos(0, MID);
    chk("withheld_req", 32'(bus.int_req), 32'd1);
    chk("withheld_vec", 32'(bus.int_vec), 32'hCF);
    goto_pos(HT - 1, VA - 1);
    step(1'b1, 1'b1);
    chk("ack_vs_evt_req", 32'(bus.int_req), 32'd1);
    chk("ack_vs_evt_vec", 32'(bus.int_vec), 32'hD7);

    // ce at half rate up to the mid-frame reset point.
    n = 0;
    while (!(mh == 150 && mv == 10) && n < 4 * HT * VT) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      n++;
    end
    chk("gated_reach_pos", 32'(mh == 150 && mv == 10), 32'd1);
    chk("pending_before_rst", 32'(bus.int_req), 32'd1);

    #2 r = 1'b0;
    #1;
    chk("arst_hcnt",    32'(bus.hcnt),    32'd0);
    chk("arst_vcnt",    32'(bus.vcnt),    32'd0);
    chk("arst_int_req", 32'(bus.int_req), 32'd0);
    chk("arst_vram_rd", 32'(bus.vram_rd), 32'd0);
    chk("arst_addr",    32'(bus.vram_addr), 32'(BASE));
    mh = 0; mv = 0; mframe = 0;
    m_req = 1'b0; m_vec = 8'h00; m_addr = BASE;
    repeat (2) @(negedge c);
    model_check();
    r = 1'b1;

    n = 0;
    while (!bus.vram_rd && n < HT) begin step(1'b1, 1'b0); n++; end
    chk("post_rst_rd",   32'(bus.vram_rd),   32'd1);
    chk("post_rst_hcnt", 32'(bus.hcnt),      32'd4);
    chk("post_rst_addr", 32'(bus.vram_addr), 32'h2401);

    repeat (8000)
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_video_scan.md
Name: inv_video_scan

Overview:
- Raster scan stage for the Invaders video path.
- Generates horizontal/vertical timing and fetches screen bytes from the 1bpp bitmap VRAM (base 0x2400, 32 bytes per line).
- Serializes each byte LSB-first into the pixel stream that drives the downstream video mix/sync logic.
- Also raises the two per-frame CPU interrupt requests (RST 1 mid-screen, RST 2 at vblank) and holds each until the CPU acknowledges it.

Parameters:
H_TOTAL, 320, pixel clocks per line
H_ACTIVE, 256, visible pixels per line (32 bytes)
HS_START, 272, first hcnt with hsync_n low
HS_END, 304, first hcnt with hsync_n high again
V_TOTAL, 262, lines per frame
V_ACTIVE, 224, visible lines
VS_START, 236, first vcnt with vsync_n low
VS_END, 240, first vcnt with vsync_n high again
MID_LINE, 96, line that raises the RST 1 request
VRAM_BASE, 16'h2400, bitmap base address

Ports:
c  in  1  clock, rising edge
r  in  1  asynchronous active-low reset
ce  in  1  pixel clock enable; all scan state advances only when ce=1
vram_addr  out  16  fetch address, registered
vram_rd  out  1  fetch strobe, one ce-cycle wide
vram_data  in  8  fetched byte, sampled two ce-cycles after vram_rd
pix  out  1  current pixel, 0 when blanked
blank  out  1  1 outside the H_ACTIVE x V_ACTIVE window
hsync_n  out  1  horizontal sync, active low
vsync_n  out  1  vertical sync, active low
hcnt  out  9  horizontal counter
vcnt  out  9  vertical counter
int_req  out  1  interrupt pending
int_vec  out  8  RST opcode for the pending interrupt
int_ack  in  1  CPU acknowledge pulse, sampled every clock regardless of ce

Behaviour:
- Clock and reset: one clock c; r is asynchronous and active-low.
- Reset values: hcnt=0, vcnt=0, shifter=0, vram_rd=0, vram_addr=VRAM_BASE, int_req=0, int_vec=8'h00. hsync_n=1, vsync_n=1, pix=0 and blank=0 are derived from these counter values.
- Counters:
  - hcnt counts 0..H_TOTAL-1 on ce and wraps to 0.
  - vcnt increments when hcnt wraps and itself wraps at V_TOTAL-1 to 0.
  - When ce=0, counters, shifter, fetch pipeline and sync outputs all hold.
- Timing outputs:
  - blank = (hcnt>=H_ACTIVE) | (vcnt>=V_ACTIVE).
  - hsync_n = 0 for HS_START<=hcnt<HS_END.
  - vsync_n = 0 for VS_START<=vcnt<VS_END.
  - All three are decoded from the registered counters, so they have zero latency relative to hcnt/vcnt.
- Fetch for group g (0..31) of visible line v:
  - The fetch point is hcnt = 8g-4, modulo H_TOTAL; for g=0 this falls on the previous line, hcnt=316 (line V_TOTAL-1 when v=0).
  - At the ce at that point, the block asserts vram_rd for one ce-cycle and drives vram_addr = VRAM_BASE + v*32 + g.
  - vram_data is captured on the ce with hcnt = 8g-2.
  - The 8-bit shifter loads the captured byte on the ce with hcnt = 8g-1.
  - No fetch occurs for non-visible lines or for g>=32; the shifter loads 0 at those load points instead.
  - vram_addr holds its last value between strobes.
- Serialization:
  - During hcnt = 8g..8g+7, pix = shifter bit (hcnt-8g), i.e. bit 0 is the leftmost pixel.
  - The shifter shifts right once per ce.
  - pix = shifter[0] & ~blank.
- Interrupts:
  - Event MID fires at the ce where the counters become hcnt=0, vcnt=MID_LINE; it sets int_req=1, int_vec=8'hCF.
  - Event VBL fires at hcnt=0, vcnt=V_ACTIVE; it sets int_req=1, int_vec=8'hD7.
  - int_ack=1 with no event in the same clock clears int_req; int_vec holds.
  - If an event and int_ack occur in the same clock, the event wins: int_req stays 1 and int_vec becomes the new vector.
  - A new event while a request is pending overwrites int_vec; there is no queueing.
- Reset mid-frame: all state returns immediately to reset values, including any pending fetch and interrupt. Scanning restarts at line 0, pixel 0 once r is released.
- Width rules: vram_addr arithmetic is 16-bit and wraps modulo 2^16.

Test Plan:
- Reset released, ce tied 1, 2 frames: hcnt wraps 319->0, vcnt wraps 261->0. hsync_n is low for exactly 32 clocks per line starting at hcnt 272. vsync_n is low for lines 236..239. blank=0 at (0,0) and blank=1 at hcnt 256 and at vcnt 224.
- Fetch check, line 5: vram_rd pulses at (hcnt 316, vcnt 4) with vram_addr=16'h24A0, and at (hcnt 4, vcnt 5) with vram_addr=16'h24A1. A model returning 8'b0000_0101 for 0x24A0 yields pix=1,0,1,0,0,0,0,0 on hcnt 0..7 of line 5.
- No fetch outside the window: no vram_rd anywhere on lines 224..260 or for hcnt 252..315 of visible lines. pix=0 throughout these regions even with vram_data forced to 8'hFF.
- Interrupt handshake: at (0,96) int_req rises with int_vec=8'hCF. An int_ack 10 clocks later drops int_req. At (0,224) int_req rises with int_vec=8'hD7. Withholding the ack until the next line 96 leaves int_req=1 and changes int_vec to 8'hCF.
- Simultaneous ack and event: int_ack pulsed in the same clock as the VBL event leaves int_req=1 with int_vec=8'hD7.
- Async reset and ce gating: with ce toggling 1-in-2, counters advance on ce cycles only. Asserting r low at (hcnt 150, vcnt 100) with int_req pending forces hcnt=0, vcnt=0, int_req=0, vram_rd=0 without a clock edge. After release, the first vram_rd occurs at hcnt 4 with vram_addr=16'h2401.
